// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, FSM encoding and decode for the seven-segment monitor
package seg7_pkg;

   localparam int PAT_W = 8;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      TRACK      = 2'd1,
      STALE      = 2'd2
   } state_e;

   // 4'hF marks a pattern that is not a decimal digit
   function automatic logic [3:0] seg7_decode(input logic [6:0] seg);
      case (seg)
         SEG_0:   return 4'd0;
         SEG_1:   return 4'd1;
         SEG_2:   return 4'd2;
         SEG_3:   return 4'd3;
         SEG_4:   return 4'd4;
         SEG_5:   return 4'd5;
         SEG_6:   return 4'd6;
         SEG_7:   return 4'd7;
         SEG_8:   return 4'd8;
         SEG_9:   return 4'd9;
         default: return 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// rtl/seg7_stable_filter.sv - input synchroniser and stability filter for the segment bus
module seg7_stable_filter
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PAT_W-1:0] pattern_i,
   output logic             accept_o,
   output logic [PAT_W-1:0] pattern_o,
   output logic [PAT_W-1:0] prev_pattern_o
);

   localparam int              CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [PAT_W-1:0] sync1_q, sync2_q, cand_q, acc_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      accept_o = (cnt_q == CNT_MAX) && (cand_q != acc_q);
      if (sync2_q != cand_q)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + CW'(1);
      else
         cnt_d = cnt_q;
   end

   // acc_q follows every accept so each new pattern fires exactly once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pattern_i;
         sync2_q <= sync1_q;
         cand_q  <= sync2_q;
         cnt_q   <= cnt_d;
         if (accept_o)
            acc_q <= cand_q;
      end
   end

   assign pattern_o      = cand_q;
   assign prev_pattern_o = acc_q;

endmodule

// File: rtl/seg7_digit_monitor.sv
// rtl/seg7_digit_monitor.sv - seven-segment digit monitor: decode, sequence check, period and timeout
module seg7_digit_monitor
   import seg7_pkg::*;
#(
   parameter int                  STABLE_CYCLES = 4,
   parameter int                  PERIOD_W      = 24,
   parameter logic [PERIOD_W-1:0] TIMEOUT       = PERIOD_W'(12_000_000)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          seg_in,
   input  logic                dot_in,
   input  logic                clear,
   output logic [3:0]          digit_out,
   output logic                dot_out,
   output logic                digit_valid,
   output logic                digit_legal,
   output logic [PERIOD_W-1:0] period_out,
   output logic [7:0]          change_count,
   output logic                seq_error,
   output logic                timeout
);

   logic             accept, accept_eff, dec_legal, dot_only;
   logic [PAT_W-1:0] pattern, prev_pattern;
   logic [3:0]       dec, expected;

   state_e state_q, state_d;

   logic [3:0]          digit_q, digit_d, prev_digit_q, prev_digit_d;
   logic                dot_q, dot_d, legal_q, legal_d, valid_q, valid_d;
   logic                seq_err_q, seq_err_d, timeout_q, timeout_d, prev_valid_q, prev_valid_d;
   logic [PERIOD_W-1:0] period_q, period_d, period_cnt_q, period_cnt_d, period_inc;
   logic [7:0]          count_q, count_d;

   seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .clk_i          (clk),
      .rst_i          (reset),
      .pattern_i      ({dot_in, seg_in}),
      .accept_o       (accept),
      .pattern_o      (pattern),
      .prev_pattern_o (prev_pattern)
   );

   always_comb begin
      accept_eff = accept & ~clear;
      dec        = seg7_decode(pattern[6:0]);
      dec_legal  = (dec != 4'hF);
      dot_only   = ((pattern ^ prev_pattern) == 8'h80);
      expected   = (prev_digit_q == 4'd9) ? 4'd0 : prev_digit_q + 4'd1;
      period_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + PERIOD_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= WAIT_FIRST;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear)
         state_d = WAIT_FIRST;
      else begin
         case (state_q)
            WAIT_FIRST: if (accept_eff) state_d = TRACK;
            TRACK:      if (!accept_eff && period_inc == TIMEOUT) state_d = STALE;
            STALE:      if (accept_eff) state_d = TRACK;
            default:    state_d = WAIT_FIRST;
         endcase
      end
   end

   always_comb begin
      digit_d      = digit_q;
      dot_d        = dot_q;
      legal_d      = legal_q;
      valid_d      = accept_eff;
      seq_err_d    = seq_err_q;
      timeout_d    = timeout_q;
      period_d     = period_q;
      period_cnt_d = period_cnt_q;
      count_d      = count_q;
      prev_digit_d = prev_digit_q;
      prev_valid_d = prev_valid_q;
      if (clear) begin
         seq_err_d    = 1'b0;
         timeout_d    = 1'b0;
         period_d     = '0;
         period_cnt_d = '0;
         count_d      = '0;
         prev_valid_d = 1'b0;
      end else begin
         if (state_q == TRACK) begin
            period_cnt_d = period_inc;
            if (!accept_eff && period_inc == TIMEOUT)
               timeout_d = 1'b1;
         end
         if (accept_eff) begin
            digit_d      = dec;
            dot_d        = pattern[7];
            legal_d      = dec_legal;
            count_d      = count_q + 8'd1;
            period_cnt_d = '0;
            if (!dec_legal)
               seq_err_d = 1'b1;
            if (state_q == TRACK) begin
               period_d = period_inc;
               if (dec_legal && prev_valid_q && !dot_only && dec != expected)
                  seq_err_d = 1'b1;
            end
            // an illegal digit never becomes the reference for the next check
            if (dec_legal) begin
               prev_digit_d = dec;
               prev_valid_d = 1'b1;
            end else if (state_q != TRACK) begin
               prev_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q      <= '0;
         dot_q        <= 1'b0;
         legal_q      <= 1'b0;
         valid_q      <= 1'b0;
         seq_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
         period_q     <= '0;
         period_cnt_q <= '0;
         count_q      <= '0;
         prev_digit_q <= '0;
         prev_valid_q <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         dot_q        <= dot_d;
         legal_q      <= legal_d;
         valid_q      <= valid_d;
         seq_err_q    <= seq_err_d;
         timeout_q    <= timeout_d;
         period_q     <= period_d;
         period_cnt_q <= period_cnt_d;
         count_q      <= count_d;
         prev_digit_q <= prev_digit_d;
         prev_valid_q <= prev_valid_d;
      end
   end

   assign digit_out    = digit_q;
   assign dot_out      = dot_q;
   assign digit_valid  = valid_q;
   assign digit_legal  = legal_q;
   assign period_out   = period_q;
   assign change_count = count_q;
   assign seq_error    = seq_err_q;
   assign timeout      = timeout_q;

endmodule
